pe_row_feeder: RTL and testbench

- Producer side of the 32-lane PE row.
- Accepts a serial stream of 32 weights, then latches them and pulses new_weight_val once.
- Then accepts a serial 7-bit sample stream into a 32-deep sliding window and presents each full window with win_val.
- Sits between the activation/weight buffers and the PE row. Its slide_data and weights buses map lane-for-lane onto the row's Slide_data_i and w_i inputs.

---
 rtl/pe_row_feeder_pkg.sv | 16 +
 rtl/pe_shift_window.sv | 28 ++
 rtl/pe_row_feeder.sv | 133 +++++++++++++
 tb/tb_pe_row_feeder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_row_feeder_pkg.sv
// Shared constants and state encoding for the PE row feeder.
// The sub-module takes its widths as parameters and does not import this package.
package pe_row_feeder_pkg;

  localparam int unsigned LANES = 32;
  localparam int unsigned DW    = 7;
  localparam int unsigned LW    = 10;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoadW  = 3'd1;
  localparam logic [2:0] StPulseW = 3'd2;
  localparam logic [2:0] StFill   = 3'd3;
  localparam logic [2:0] StSlide  = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

endpackage

// File: rtl/pe_shift_window.sv
// Lane-parallel shift register: on enable every lane takes its upper neighbour and
// the serial input enters the top lane, so lane 0 always holds the oldest entry.
module pe_shift_window #(
  parameter int unsigned Lanes = 32,
  parameter int unsigned Dw    = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [Dw-1:0]         din_i,
  output logic [Lanes*Dw-1:0]   data_o
);

  logic [Lanes*Dw-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = {din_i, data_q[Lanes*Dw-1:Dw]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/pe_row_feeder.sv
// Producer for the 32-lane PE row: loads a serial weight set, then streams samples
// through a sliding window, flagging each full window with win_val.
module pe_row_feeder
  import pe_row_feeder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LW-1:0]       seq_len,
  input  logic [DW-1:0]       w_in,
  input  logic                w_in_valid,
  output logic                w_in_ready,
  input  logic [DW-1:0]       x_in,
  input  logic                x_in_valid,
  output logic                x_in_ready,
  output logic [LANES*DW-1:0] weights,
  output logic                new_weight_val,
  output logic [LANES*DW-1:0] slide_data,
  output logic                win_val,
  output logic                busy,
  output logic                done,
  output logic                start_err
);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] cnt_inc;
  logic          win_val_q, win_val_d;
  logic          start_err_q, start_err_d;
  logic          w_acc, x_acc;

  // Ready depends on state only so that no valid->ready combinational path exists.
  assign w_in_ready = (state_q == StLoadW);
  assign x_in_ready = (state_q == StFill) || (state_q == StSlide);
  assign w_acc      = w_in_ready && w_in_valid;
  assign x_acc      = x_in_ready && x_in_valid;
  assign cnt_inc    = cnt_q + LW'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    win_val_d   = 1'b0;
    start_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (seq_len >= LW'(LANES)) begin
            len_d   = seq_len;
            cnt_d   = '0;
            state_d = StLoadW;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      StLoadW: begin
        if (w_acc) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LW'(LANES)) begin
            cnt_d   = '0;
            state_d = StPulseW;
          end
        end
      end
      StPulseW: state_d = StFill;
      StFill: begin
        if (x_acc) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LW'(LANES)) begin
            win_val_d = 1'b1;
            state_d   = (cnt_inc == len_q) ? StDone : StSlide;
          end
        end
      end
      StSlide: begin
        if (x_acc) begin
          cnt_d     = cnt_inc;
          win_val_d = 1'b1;
          if (cnt_inc == len_q) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      win_val_q   <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      win_val_q   <= win_val_d;
      start_err_q <= start_err_d;
    end
  end

  pe_shift_window #(
    .Lanes (LANES),
    .Dw    (DW)
  ) u_weights (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (w_acc),
    .din_i  (w_in),
    .data_o (weights)
  );

  pe_shift_window #(
    .Lanes (LANES),
    .Dw    (DW)
  ) u_window (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (x_acc),
    .din_i  (x_in),
    .data_o (slide_data)
  );

  assign new_weight_val = (state_q == StPulseW);
  assign win_val        = win_val_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign start_err      = start_err_q;

endmodule

// File: tb/tb_pe_row_feeder.sv
// Scoreboarded random bench for pe_row_feeder: expected weight sets and windows are
// computed from the sample lists and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_pe_row_feeder;
  import pe_row_feeder_pkg::*;

  localparam int unsigned BW = LANES * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] seq_len = '0;
  logic [DW-1:0] w_in = '0;
  logic [DW-1:0] x_in = '0;
  logic          w_in_valid = 1'b0;
  logic          x_in_valid = 1'b0;
  logic          w_in_ready, x_in_ready, new_weight_val, win_val, busy, done, start_err;
  logic [BW-1:0] weights, slide_data;
  logic [2*BW+6:0] all_outs;

  pe_row_feeder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .seq_len        (seq_len),
    .w_in           (w_in),
    .w_in_valid     (w_in_valid),
    .w_in_ready     (w_in_ready),
    .x_in           (x_in),
    .x_in_valid     (x_in_valid),
    .x_in_ready     (x_in_ready),
    .weights        (weights),
    .new_weight_val (new_weight_val),
    .slide_data     (slide_data),
    .win_val        (win_val),
    .busy           (busy),
    .done           (done),
    .start_err      (start_err)
  );

  assign all_outs = {w_in_ready, x_in_ready, weights, new_weight_val, slide_data,
                     win_val, busy, done, start_err};

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_seen = 0;

  logic [DW-1:0] wv[LANES];
  logic [DW-1:0] sv[1024];
  logic [BW-1:0] exp_w_q[$];
  logic [BW-1:0] exp_win_q[$];
  bit            exp_last_q[$];
  logic [BW-1:0] model_w;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents weights or a window.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_err) err_seen++;
      if (new_weight_val) begin
        if (exp_w_q.size() == 0) chk("nwv_extra", new_weight_val, 1'b0);
        else chk("weights", weights, exp_w_q.pop_front());
      end
      if (win_val) begin
        if (exp_win_q.size() == 0) chk("win_extra", win_val, 1'b0);
        else begin
          chk("window", slide_data, exp_win_q.pop_front());
          chk("done_on_last", done, exp_last_q.pop_front());
        end
      end
      if (done) chk("done_xrdy", x_in_ready, 1'b0);
    end
  end

  // dmode 0: weights 1..LANES and samples 0..len-1; else random data.
  // vmode 0: valid always; 1: toggling; else random.
  task automatic run_job(input int len, input int dmode, input int vmode, input bit inject,
                         input int abort_x);
    int wi = 0;
    int xi = 0;
    int cyc = 0;
    int err0;
    bit acc_w, acc_x;
    bit injected = 1'b0;
    logic [BW-1:0] v;
    for (int j = 0; j < LANES; j++) wv[j] = (dmode == 0) ? DW'(j + 1) : DW'($urandom);
    for (int i = 0; i < len; i++) sv[i] = (dmode == 0) ? DW'(i) : DW'($urandom);
    for (int j = 0; j < LANES; j++) v[j*DW +: DW] = wv[j];
    model_w = v;
    exp_w_q.push_back(v);
    for (int k = 0; k <= len - LANES; k++) begin
      for (int j = 0; j < LANES; j++) v[j*DW +: DW] = sv[k + j];
      exp_win_q.push_back(v);
      exp_last_q.push_back(k == len - LANES);
    end
    err0 = err_seen;
    start = 1'b1;
    seq_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    while (1) begin
      w_in = (wi < LANES) ? wv[wi] : DW'($urandom);
      x_in = (xi < len) ? sv[xi] : DW'($urandom);
      if (vmode == 0) begin
        w_in_valid = 1'b1; x_in_valid = 1'b1;
      end else if (vmode == 1) begin
        w_in_valid = (cyc % 2 == 0); x_in_valid = (cyc % 2 == 0);
      end else begin
        w_in_valid = ($urandom_range(0, 3) != 0); x_in_valid = ($urandom_range(0, 3) != 0);
      end
      if (inject && !injected && xi > LANES && xi < len) begin
        start = 1'b1;
        seq_len = LW'($urandom_range(0, 1023));
        injected = 1'b1;
      end
      acc_w = w_in_valid && w_in_ready;
      acc_x = x_in_valid && x_in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (acc_w) wi++;
      if (acc_x) xi++;
      chk("nwv_timing", new_weight_val, acc_w && wi == LANES);
      chk("winval_timing", win_val, acc_x && xi >= LANES);
      if (acc_w && wi == LANES) chk("wrdy_after_load", w_in_ready, 1'b0);
      if (abort_x > 0 && xi == abort_x) begin
        w_in_valid = 1'b0;
        x_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("abort_outs_zero", all_outs, '0);
        exp_w_q.delete();
        exp_win_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) break;
      if (cyc > 4000) begin
        chk("job_timeout", done, 1'b1);
        break;
      end
    end
    w_in_valid = 1'b0;
    x_in_valid = 1'b0;
    @(negedge clk); #1;
    chk("samples_used", xi, len);
    chk("windows_left", exp_win_q.size(), 0);
    chk("wsets_left", exp_w_q.size(), 0);
    chk("weights_held", weights, model_w);
    chk("no_start_err", err_seen, err0);
    @(posedge clk); #1;
    chk("idle_after_done", busy, 1'b0);
    exp_win_q.delete();
    exp_w_q.delete();
    exp_last_q.delete();
  endtask

  task automatic err_test();
    start = 1'b1;
    seq_len = LW'(LANES - 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_err_pulse", start_err, 1'b1);
    chk("err_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("start_err_clear", start_err, 1'b0);
    chk("err_busy_after", busy, 1'b0);
  endtask

  initial begin
    #12;
    chk("reset_outs", all_outs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outs", {w_in_ready, x_in_ready, busy, done}, '0);
    run_job(32, 0, 0, 1'b0, 0);
    run_job(40, 0, 0, 1'b0, 0);
    run_job(34, 0, 1, 1'b0, 0);
    err_test();
    run_job(40, 1, 2, 1'b1, 0);
    run_job(45, 1, 0, 1'b0, 38);
    run_job(32, 0, 0, 1'b0, 0);
    for (int n = 0; n < 4; n++) run_job(int'($urandom_range(32, 80)), 1, 2, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
